// File: rtl/user_uart_pkg.sv
// Shared types and constants for the user-area UART transmitter.
package user_uart_pkg;

    localparam int   DIV_W     = 16;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d,
                                                   input logic [DIV_W-1:0] lo);
        return (d < lo) ? lo : d;
    endfunction

endpackage

// File: rtl/user_uart_tx_if.sv
// Byte handshake into the UART transmitter; a byte moves on tx_valid & tx_ready.
interface user_uart_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/user_uart_fifo.sv
// Synchronous FIFO with a level counter; read data is the head entry, shown combinationally.
// Push is ignored when full (even with a simultaneous pop), pop is ignored when empty.
module user_uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/user_uart_tx.sv
// 8N1/8N2 UART transmitter fed by a byte FIFO; ser_tx drops one cycle after a byte lands in an idle, empty path.
// Backpressure: tx_ready = !full; frames run back-to-back with no idle gap while data and tx_en are present.
module user_uart_tx
    import user_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1,
    parameter int DIV_MIN    = 4
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic [DIV_W-1:0]            clk_div,
    input  logic                        tx_en,
    user_uart_tx_if.slave               tx,
    output logic                        ser_tx,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int CW = DIV_W + 1;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_new;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    stop_cnt;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_nxt;
    logic [7:0]       shreg;
    logic [7:0]       shreg_nxt;
    logic             ser_nxt;
    logic             pop;
    logic             bit_end;
    logic             can_start;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dat;

    user_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (tx.tx_valid),
        .pop   (pop),
        .wdata (tx.tx_data),
        .rdata (fifo_dat),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign div_new     = clamp_div(clk_div, DIV_W'(DIV_MIN));
    assign bit_end     = (cnt == '0);
    assign can_start   = !fifo_empty && tx_en;
    assign bit_cnt     = {1'b0, div_q} - CW'(1);
    assign stop_cnt    = (STOP_BITS == 2) ? ({div_q, 1'b0} - CW'(1)) : bit_cnt;
    assign tx.tx_ready = !fifo_full;
    assign tx_busy     = (state != IDLE) || !fifo_empty;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (can_start) state_nxt = START;
            START:   if (bit_end) state_nxt = DATA;
            DATA:    if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
            STOP:    if (bit_end) state_nxt = can_start ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Every entry into START pops a byte and re-latches the divider, so a
    // clk_div change only takes effect on the next frame.
    always_comb begin
        pop       = (state_nxt == START) && (state != START);
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        shreg_nxt = shreg;
        ser_nxt   = ser_tx;
        case (state)
            IDLE: ser_nxt = IDLE_LVL;
            START: begin
                if (!bit_end) begin
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    cnt_nxt = bit_cnt;
                    bit_nxt = '0;
                    ser_nxt = shreg[0];
                end
            end
            DATA: begin
                if (!bit_end) begin
                    cnt_nxt = cnt - CW'(1);
                end else if (bit_idx == 3'd7) begin
                    cnt_nxt = stop_cnt;
                    ser_nxt = STOP_LVL;
                end else begin
                    cnt_nxt   = bit_cnt;
                    bit_nxt   = bit_idx + 3'd1;
                    shreg_nxt = shreg >> 1;
                    ser_nxt   = shreg[1];
                end
            end
            STOP: begin
                if (!bit_end) cnt_nxt = cnt - CW'(1);
                else          ser_nxt = IDLE_LVL;
            end
            default: ser_nxt = IDLE_LVL;
        endcase
        if (pop) begin
            shreg_nxt = fifo_dat;
            cnt_nxt   = {1'b0, div_new} - CW'(1);
            ser_nxt   = START_LVL;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ser_tx  <= IDLE_LVL;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            div_q   <= '0;
        end else begin
            ser_tx  <= ser_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            shreg   <= shreg_nxt;
            if (pop) div_q <= div_new;
        end
    end

endmodule

// File: tb/tb_user_uart_tx.sv
// Bench for user_uart_tx: vector table, hand sequences and random frames checked against a waveform model.
module tb_user_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] clk_div;
    logic [15:0] clk_div2;
    logic        tx_en;
    logic        tx_en2;
    logic        ser_tx;
    logic        tx_busy;
    logic        ser2;
    logic        busy2;
    logic [2:0]  fifo_level;
    logic [2:0]  level2;

    user_uart_tx_if bus ();
    user_uart_tx_if bus2 ();

    user_uart_tx #(.FIFO_DEPTH(4), .STOP_BITS(1), .DIV_MIN(4)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .clk_div    (clk_div),
        .tx_en      (tx_en),
        .tx         (bus),
        .ser_tx     (ser_tx),
        .tx_busy    (tx_busy),
        .fifo_level (fifo_level)
    );

    user_uart_tx #(.FIFO_DEPTH(4), .STOP_BITS(2), .DIV_MIN(4)) dut2 (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .clk_div    (clk_div2),
        .tx_en      (tx_en2),
        .tx         (bus2),
        .ser_tx     (ser2),
        .tx_busy    (busy2),
        .fifo_level (level2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bit         rec  = 1'b0;
    bit         rec2 = 1'b0;
    bit         tr[$];
    bit         trb[$];
    bit         tr2[$];
    logic [7:0] eb[$];
    int         ed[$];

    always @(negedge clk) begin
        if (rec) begin
            tr.push_back(ser_tx);
            trb.push_back(tx_busy);
        end
        if (rec2) tr2.push_back(ser2);
    end

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        int          width;
        logic [9:0]  frame;   // bit i = i-th bit on the line
    } vec_t;
    vec_t vt[3];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        bus.tx_valid = 1'b1;
        bus.tx_data  = b;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while (tx_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " idle timeout"}, tx_busy, 0);
    endtask

    task automatic exp_clear();
        eb.delete();
        ed.delete();
    endtask

    task automatic exp_add(input logic [7:0] b, input int d);
        eb.push_back(b);
        ed.push_back(d);
    endtask

    // Reference line model: each frame is start(0), 8 data bits LSB first, sb stop bits (1),
    // every bit held d samples, frames contiguous; the line is idle-high around them.
    task automatic check_wave(input string nm, input bit t[$], input logic [7:0] bytes[$],
                              input int divs[$], input int sb);
        int p = 0;
        int errs;
        int zeros = 0;
        while (p < t.size() && t[p] == 1'b1) p++;
        foreach (bytes[f]) begin
            errs = 0;
            for (int j = 0; j < 9 + sb; j++) begin
                bit e;
                e = (j == 0) ? 1'b0 : (j <= 8) ? bytes[f][j-1] : 1'b1;
                for (int c = 0; c < divs[f]; c++) begin
                    if (p >= t.size() || t[p] != e) errs++;
                    p++;
                end
            end
            chk($sformatf("%s frame%0d", nm, f), errs, 0);
        end
        for (; p < t.size(); p++) if (!t[p]) zeros++;
        chk({nm, " tail"}, zeros, 0);
    endtask

    function automatic string decode(input bit t[$], input int div);
        string s = "";
        int    i = 0;
        while (i < t.size()) begin
            if (t[i] == 1'b0 && i + 10 * div <= t.size()) begin
                logic [7:0] ch;
                for (int k = 0; k < 8; k++) ch[k] = t[i + div * (1 + k) + div / 2];
                s = $sformatf("%s%c", s, ch);
                i += 10 * div;
            end else begin
                i++;
            end
        end
        return s;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb[5];
        logic [7:0] b1;
        logic [7:0] b2;
        int         d;
        int         s;
        int         q;
        int         zeros;
        string      got;
        string      want;

        vt[0] = '{8'hA5, 16'd4, 4, 10'h34A};
        vt[1] = '{8'h3C, 16'd1, 4, 10'h278};
        vt[2] = '{8'h81, 16'd6, 6, 10'h302};

        rst           = 1'b1;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = 8'h00;
        bus2.tx_valid = 1'b0;
        bus2.tx_data  = 8'h00;
        clk_div       = 16'd4;
        clk_div2      = 16'd8;
        tx_en         = 1'b1;
        tx_en2        = 1'b1;
        cyc(3);
        chk("reset ser_tx", ser_tx, 1);
        chk("reset tx_ready", bus.tx_ready, 1);
        chk("reset tx_busy", tx_busy, 0);
        chk("reset fifo_level", fifo_level, 0);
        rst = 1'b0;
        cyc(2);

        // Single frames from the vector table, sampled cycle by cycle.
        foreach (vt[v]) begin
            clk_div = vt[v].div;
            push(vt[v].data);
            chk($sformatf("vec%0d latency idle", v), ser_tx, 1);
            for (int j = 0; j < 10; j++) begin
                for (int c = 0; c < vt[v].width; c++) begin
                    @(negedge clk);
                    chk($sformatf("vec%0d bit%0d", v, j), ser_tx, vt[v].frame[j]);
                end
            end
            chk($sformatf("vec%0d busy last", v), tx_busy, 1);
            @(negedge clk);
            chk($sformatf("vec%0d busy drop", v), tx_busy, 0);
            cyc(3);
        end

        // Back-to-back frames with simultaneous push/pop.
        clk_div = 16'd4;
        tr.delete();
        trb.delete();
        rec = 1'b1;
        cyc(2);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h00;
        @(negedge clk);
        chk("b2b level1", fifo_level, 1);
        bus.tx_data = 8'hFF;
        @(negedge clk);
        chk("b2b push+pop level", fifo_level, 1);
        bus.tx_data = 8'h55;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        chk("b2b level2", fifo_level, 2);
        wait_idle("b2b", 400);
        cyc(5);
        rec = 1'b0;
        exp_clear();
        exp_add(8'h00, 4);
        exp_add(8'hFF, 4);
        exp_add(8'h55, 4);
        check_wave("b2b", tr, eb, ed, 1);
        s = 0;
        while (s < tr.size() && tr[s]) s++;
        q = s;
        while (q < trb.size() && trb[q]) q++;
        chk("b2b busy span", q - s, 120);

        // Fill with transmitter disabled; fifth byte must be dropped.
        tx_en = 1'b0;
        foreach (rb[i]) rb[i] = 8'($urandom_range(0, 255));
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.tx_data = rb[i];
            @(negedge clk);
            if (i == 3) begin
                chk("full tx_ready", bus.tx_ready, 0);
                chk("full level", fifo_level, 4);
            end
        end
        bus.tx_valid = 1'b0;
        chk("full level after drop", fifo_level, 4);
        chk("full busy while disabled", tx_busy, 1);
        cyc(20);
        chk("full line idle while disabled", ser_tx, 1);
        tr.delete();
        rec   = 1'b1;
        tx_en = 1'b1;
        wait_idle("full", 400);
        cyc(5);
        rec = 1'b0;
        exp_clear();
        for (int i = 0; i < 4; i++) exp_add(rb[i], 4);
        check_wave("full", tr, eb, ed, 1);

        // Divider change mid-frame applies from the next frame only.
        b1 = 8'($urandom_range(0, 255));
        b2 = 8'($urandom_range(0, 255));
        clk_div = 16'd4;
        tr.delete();
        rec = 1'b1;
        cyc(1);
        push(b1);
        cyc(10);
        clk_div = 16'd8;
        push(b2);
        wait_idle("divlatch", 600);
        cyc(5);
        rec = 1'b0;
        exp_clear();
        exp_add(b1, 4);
        exp_add(b2, 8);
        check_wave("divlatch", tr, eb, ed, 1);

        // tx_en dropped mid-frame: frame completes, remaining data is held.
        clk_div = 16'd4;
        tr.delete();
        rec = 1'b1;
        push(b2);
        push(b1);
        cyc(10);
        tx_en = 1'b0;
        cyc(60);
        rec = 1'b0;
        chk("en-off level", fifo_level, 1);
        chk("en-off busy", tx_busy, 1);
        exp_clear();
        exp_add(b2, 4);
        check_wave("en-off", tr, eb, ed, 1);
        tx_en = 1'b1;
        wait_idle("en-on", 200);
        chk("en-on level", fifo_level, 0);

        // Random bytes and dividers, including values below the clamp.
        for (int r = 0; r < 6; r++) begin
            b1 = 8'($urandom_range(0, 255));
            d  = $urandom_range(0, 9);
            clk_div = 16'(d);
            tr.delete();
            rec = 1'b1;
            cyc(1);
            push(b1);
            wait_idle("rand", 1000);
            cyc(3);
            rec = 1'b0;
            exp_clear();
            exp_add(b1, (d < 4) ? 4 : d);
            check_wave($sformatf("rand%0d", r), tr, eb, ed, 1);
        end

        // Two stop bits at divider 8.
        b1 = 8'($urandom_range(0, 255));
        b2 = 8'($urandom_range(0, 255));
        tr2.delete();
        rec2 = 1'b1;
        cyc(1);
        bus2.tx_valid = 1'b1;
        bus2.tx_data  = b1;
        @(negedge clk);
        bus2.tx_data = b2;
        @(negedge clk);
        bus2.tx_valid = 1'b0;
        q = 0;
        while (busy2 && q < 1000) begin
            @(negedge clk);
            q++;
        end
        chk("stop2 idle timeout", busy2, 0);
        cyc(5);
        rec2 = 1'b0;
        exp_clear();
        exp_add(b1, 8);
        exp_add(b2, 8);
        check_wave("stop2", tr2, eb, ed, 2);

        // Reset during data bit 3 with two bytes queued.
        clk_div = 16'd4;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h07;
        @(negedge clk);
        bus.tx_data = 8'hF0;
        @(negedge clk);
        bus.tx_data = 8'h3C;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        cyc(16);
        chk("pre-reset level", fifo_level, 2);
        chk("pre-reset line low in bit3", ser_tx, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset ser_tx", ser_tx, 1);
        chk("midreset level", fifo_level, 0);
        chk("midreset busy", tx_busy, 0);
        tr.delete();
        rec = 1'b1;
        cyc(100);
        rec = 1'b0;
        zeros = 0;
        foreach (tr[i]) if (!tr[i]) zeros++;
        chk("midreset no new frames", zeros, 0);

        // Loopback through the bench-side UART decoder.
        clk_div = 16'd100;
        tr.delete();
        rec = 1'b1;
        cyc(2);
        push(8'h4F);
        push(8'h4B);
        push(8'h0A);
        wait_idle("loop", 5000);
        cyc(20);
        rec = 1'b0;
        got  = decode(tr, 100);
        want = "OK\n";
        chk("loopback length", got.len(), 3);
        for (int k = 0; k < 3; k++) chk($sformatf("loopback char%0d", k), got[k], want[k]);
        if (got.len() >= 2) $display("loopback received: %s", got.substr(0, 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
